bsg_down_io_assembler: RTL and testbench

Downstream input stage of the off-chip link, directly upstream of the final core-output stage. Accepts one byte per cycle from the I/O pins into a 64-entry byte FIFO, packs four consecutive bytes into two 16-bit half-words (`core_data0`, `core_data1`), and presents them with `child_valid` to the final stage. It returns flow-control tokens to the remote sender as bytes drain.

---
 rtl/bsg_down_pkg.sv | 15 +
 rtl/bsg_down_byte_fifo.sv | 54 +++++
 rtl/bsg_down_io_assembler.sv | 114 +++++++++++
 tb/tb_bsg_down_io_assembler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_down_pkg.sv
// Shared constants and types for the downstream I/O assembler.
// Holds the default sizing, the lane count and the assembly FSM states.
package bsg_down_pkg;

    localparam int unsigned DEPTH_LG_DEF    = 6;
    localparam int unsigned TOKEN_BATCH_DEF = 4;
    localparam int unsigned LANES           = 4;
    localparam int unsigned LANE_W          = $clog2(LANES);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_down_byte_fifo.sv
// Byte FIFO with wrap-bit pointers. A push is ignored while full.
// There is no write-to-read bypass.
module bsg_down_byte_fifo
    import bsg_down_pkg::*;
#(
    parameter int unsigned DEPTH_LG = DEPTH_LG_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LG;
    localparam logic [DEPTH_LG:0] PTR_ONE = (DEPTH_LG+1)'(1);

    logic [7:0]        mem_q [DEPTH];
    logic [DEPTH_LG:0] wptr_q;
    logic [DEPTH_LG:0] rptr_q;
    logic              wr_s;

    assign full_o  = (wptr_q[DEPTH_LG] != rptr_q[DEPTH_LG]) &&
                     (wptr_q[DEPTH_LG-1:0] == rptr_q[DEPTH_LG-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign wr_s    = push_i && !full_o;
    assign data_o  = mem_q[rptr_q[DEPTH_LG-1:0]];

    // Pointer update; the caller only pops when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_s) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_i) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_q[wptr_q[DEPTH_LG-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/bsg_down_io_assembler.sv
// Packs four FIFO bytes into two half-words for the final core stage.
// Returns one credit token per TOKEN_BATCH bytes drained.
module bsg_down_io_assembler
    import bsg_down_pkg::*;
#(
    parameter int unsigned DEPTH_LG    = DEPTH_LG_DEF,
    parameter int unsigned TOKEN_BATCH = TOKEN_BATCH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_valid_in,
    input  logic [7:0]  io_data_in,
    input  logic        child_ready,
    output logic        child_valid,
    output logic [15:0] core_data0,
    output logic [15:0] core_data1,
    output logic        io_token_out,
    output logic        full,
    output logic        overflow
);

    localparam int unsigned TOK_W = (TOKEN_BATCH > 1) ? $clog2(TOKEN_BATCH) : 1;
    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(TOKEN_BATCH - 1);
    localparam logic [TOK_W-1:0] TOK_ONE  = TOK_W'(1);

    state_e            state_q;
    logic [LANE_W-1:0] byte_cnt_q;
    logic [TOK_W-1:0]  tok_cnt_q;
    logic [15:0]       data0_q;
    logic [15:0]       data1_q;
    logic              valid_q;
    logic              token_q;
    logic              overflow_q;

    logic [7:0]        fifo_data_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              tok_wrap_s;

    assign pop_s      = (state_q == ST_FILL) && !empty_s;
    assign tok_wrap_s = (tok_cnt_q == TOK_LAST);

    bsg_down_byte_fifo #(
        .DEPTH_LG (DEPTH_LG)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (io_valid_in),
        .data_i  (io_data_in),
        .pop_i   (pop_s),
        .data_o  (fifo_data_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Assembly FSM, lane packing, token counting and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            byte_cnt_q <= '0;
            tok_cnt_q  <= '0;
            data0_q    <= 16'h0000;
            data1_q    <= 16'h0000;
            valid_q    <= 1'b0;
            token_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            token_q <= pop_s && tok_wrap_s;
            if (pop_s) begin
                tok_cnt_q <= tok_wrap_s ? '0 : (tok_cnt_q + TOK_ONE);
            end
            if (io_valid_in && full_s) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_FILL: begin
                    if (pop_s) begin
                        case (byte_cnt_q)
                            2'd0:    data0_q[7:0]  <= fifo_data_s;
                            2'd1:    data0_q[15:8] <= fifo_data_s;
                            2'd2:    data1_q[7:0]  <= fifo_data_s;
                            2'd3:    data1_q[15:8] <= fifo_data_s;
                            default: data0_q       <= data0_q;
                        endcase
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (child_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_FILL;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign child_valid  = valid_q;
    assign core_data0   = data0_q;
    assign core_data1   = data1_q;
    assign io_token_out = token_q;
    assign full         = full_s;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_bsg_down_io_assembler.sv
// Self-checking bench: a table for the single-word case, directed corner
// sequences, and random traffic compared against a queue-based reference model.
module tb_bsg_down_io_assembler;

    localparam int DEPTH = 64;
    localparam int TB    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_valid_in = 1'b0;
    logic [7:0]  io_data_in = 8'h00;
    logic        child_ready = 1'b0;
    logic        child_valid;
    logic [15:0] core_data0;
    logic [15:0] core_data1;
    logic        io_token_out;
    logic        full;
    logic        overflow;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_lane[4];
    int         m_idx;
    int         m_pops;
    bit         m_hold;
    bit         m_tok;
    bit         m_ovf;

    typedef struct {
        bit          v;
        logic [7:0]  d;
        bit          r;
        bit          cv;
        logic [15:0] d0;
        logic [15:0] d1;
        bit          tok;
    } vec_t;

    vec_t tbl[8];

    bsg_down_io_assembler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .io_valid_in  (io_valid_in),
        .io_data_in   (io_data_in),
        .child_ready  (child_ready),
        .child_valid  (child_valid),
        .core_data0   (core_data0),
        .core_data1   (core_data1),
        .io_token_out (io_token_out),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic m_reset();
        q.delete();
        for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
        m_idx = 0; m_pops = 0; m_hold = 1'b0; m_tok = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic m_edge(input bit v, input logic [7:0] d, input bit r);
        bit pop;
        bit can_push;
        pop      = !m_hold && (q.size() != 0);
        can_push = (q.size() < DEPTH);
        m_tok    = 1'b0;
        if (v && !can_push) m_ovf = 1'b1;
        if (pop) begin
            m_lane[m_idx] = q.pop_front();
            m_idx++;
            m_pops++;
            m_tok = ((m_pops % TB) == 0);
            if (m_idx == 4) begin
                m_idx  = 0;
                m_hold = 1'b1;
            end
        end else if (m_hold && r) begin
            m_hold = 1'b0;
        end
        if (v && can_push) q.push_back(d);
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [15:0] e0;
        logic [15:0] e1;
        bit          ef;
        e0 = {m_lane[1], m_lane[0]};
        e1 = {m_lane[3], m_lane[2]};
        ef = (q.size() == DEPTH);
        n_vec++;
        if (child_valid !== m_hold || core_data0 !== e0 || core_data1 !== e1 ||
            io_token_out !== m_tok || full !== ef || overflow !== m_ovf) begin
            n_bad++;
            $display("FAIL %s @%0t: got cv=%0b d0=%h d1=%h tok=%0b full=%0b ovf=%0b, expected cv=%0b d0=%h d1=%h tok=%0b full=%0b ovf=%0b",
                     tag, $time, child_valid, core_data0, core_data1, io_token_out, full, overflow,
                     m_hold, e0, e1, m_tok, ef, m_ovf);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit r, input bit chk, input string tag);
        @(negedge clk);
        io_valid_in = v; io_data_in = d; child_ready = r;
        @(posedge clk);
        m_edge(v, d, r);
        #1;
        if (chk) check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        io_valid_in = 1'b0; io_data_in = 8'h00; child_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val({tag, "_zero"},
                  {child_valid, io_token_out, overflow, full, core_data0, core_data1 != 16'h0000},
                  32'h0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int words;
        int toks;
        int credits;
        int sent;
        int cyc;
        bit v;

        m_reset();
        // Power-on reset: every output must be zero.
        #12;
        check_val("por_cv", {31'd0, child_valid}, 32'd0);
        check_val("por_data", {core_data1, core_data0}, 32'd0);
        check_val("por_flags", {29'd0, io_token_out, full, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, table driven.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 16'h0011, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 16'h2211, 16'h0000, 1'b0};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 16'h2211, 16'h0033, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h2211, 16'h4433, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 16'h2211, 16'h4433, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 16'h2211, 16'h4433, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 16'h2211, 16'h4433, 1'b0};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, "tbl");
            n_vec++;
            if (child_valid !== tbl[i].cv || core_data0 !== tbl[i].d0 ||
                core_data1 !== tbl[i].d1 || io_token_out !== tbl[i].tok ||
                full !== 1'b0 || overflow !== 1'b0) begin
                n_bad++;
                $display("FAIL tbl[%0d]: got cv=%0b d0=%h d1=%h tok=%0b, expected cv=%0b d0=%h d1=%h tok=%0b",
                         i, child_valid, core_data0, core_data1, io_token_out,
                         tbl[i].cv, tbl[i].d0, tbl[i].d1, tbl[i].tok);
            end
        end

        // Fill to full, overflow, back-pressure, simultaneous push/pop when full.
        do_reset("fill");
        for (int i = 0; i < 68; i++) step(1'b1, 8'(i), 1'b0, 1'b1, "fill");
        check_val("fill_full", {31'd0, full}, 32'd1);
        step(1'b1, 8'hEE, 1'b0, 1'b1, "ovf_push");
        check_val("ovf_set", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "backpressure");
        step(1'b0, 8'h00, 1'b1, 1'b1, "handshake");
        step(1'b1, 8'hEF, 1'b0, 1'b1, "full_pushpop");
        check_val("full_pushpop_full", {31'd0, full}, 32'd0);
        check_val("full_pushpop_ovf", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 90; i++) step(1'b0, 8'h00, 1'b1, 1'b1, "drain");

        // Wrap-around stream with a credit-respecting sender.
        do_reset("wrap");
        words = 0; toks = 0; credits = DEPTH; sent = 0; cyc = 0;
        while (words < 50 && cyc < 3000) begin
            v = (sent < 200) && (credits > 0);
            step(v, 8'(sent), 1'b1, 1'b1, "wrap");
            if (v) begin
                credits--;
                sent++;
            end
            if (io_token_out === 1'b1) begin
                credits += TB;
                toks++;
            end
            if (child_valid === 1'b1) begin
                check_val("wrap_word",
                          {core_data1, core_data0},
                          {8'(4*words+3), 8'(4*words+2), 8'(4*words+1), 8'(4*words)});
                words++;
            end
            cyc++;
        end
        check_val("wrap_words", 32'(words), 32'd50);
        check_val("wrap_tokens", 32'(toks), 32'd50);
        check_val("wrap_ovf", {31'd0, overflow}, 32'd0);

        // Async reset mid-word, then four fresh bytes.
        do_reset("mid_pre");
        step(1'b1, 8'hA1, 1'b0, 1'b1, "mid");
        step(1'b1, 8'hA2, 1'b0, 1'b1, "mid");
        step(1'b0, 8'h00, 1'b0, 1'b1, "mid");
        do_reset("mid_rst");
        step(1'b1, 8'hB1, 1'b0, 1'b1, "mid_new");
        step(1'b1, 8'hB2, 1'b0, 1'b1, "mid_new");
        step(1'b1, 8'hB3, 1'b0, 1'b1, "mid_new");
        step(1'b1, 8'hB4, 1'b0, 1'b1, "mid_new");
        step(1'b0, 8'h00, 1'b0, 1'b1, "mid_new");
        check_val("mid_word", {15'd0, child_valid, core_data0}, {15'd0, 1'b1, 16'hB2B1});
        check_val("mid_word_hi", {16'd0, core_data1}, {16'd0, 16'hB4B3});

        // Random traffic, including occasional overrun.
        do_reset("rand");
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0), 1'b1, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
